// File: rtl/quad_decoder.sv
// Quadrature encoder receiver: synchronizes and debounces A/B, decodes steps into
// a signed position, reports direction with stall timeout, and measures steps per window.
module quad_decoder #(
    parameter int CNT_W     = 16,
    parameter int FILT_LEN  = 3,
    parameter int STALL_CYC = 1000000,
    parameter int WIN_CYC   = 100000,
    parameter int SPD_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_out,
    output logic [1:0]       dir_mode,
    output logic             step_valid,
    output logic [SPD_W-1:0] speed_out,
    output logic             err
);

    localparam int STALL_W = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;
    localparam int WIN_W   = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYC - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_CYC - 1);

    logic [1:0]            sync1_reg, sync2_reg;
    logic [2*FILT_LEN-1:0] hist_reg;
    logic [FILT_LEN-1:0]   match_vec;
    logic                  accept;
    logic [1:0]            s_reg, s_old_reg;
    logic                  s_upd_reg;
    logic                  fwd_step, rev_step, dbl_step, step_now;
    logic [CNT_W-1:0]      cnt_reg;
    logic [1:0]            dir_reg;
    logic                  step_reg, err_reg;
    logic [STALL_W-1:0]    stall_reg;
    logic [WIN_W-1:0]      win_reg;
    logic [SPD_W-1:0]      acc_reg, speed_reg, acc_sat;
    logic [SPD_W:0]        acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            hist_reg  <= '0;
        end else begin
            sync1_reg <= {enc_a, enc_b};
            sync2_reg <= sync1_reg;
            hist_reg  <= {hist_reg[2*FILT_LEN-3:0], sync2_reg};
        end
    end

    // Newest sample sits in hist_reg[1:0]; every slot must agree with it.
    generate
        for (genvar gi = 0; gi < FILT_LEN; gi++) begin : g_match
            assign match_vec[gi] = (hist_reg[2*gi +: 2] == hist_reg[1:0]);
        end
    endgenerate

    assign accept = (&match_vec) && (hist_reg[1:0] != s_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg     <= '0;
            s_old_reg <= '0;
            s_upd_reg <= 1'b0;
        end else begin
            s_upd_reg <= accept;
            if (accept) begin
                s_old_reg <= s_reg;
                s_reg     <= hist_reg[1:0];
            end
        end
    end

    always_comb begin
        fwd_step = 1'b0;
        rev_step = 1'b0;
        dbl_step = 1'b0;
        if (s_upd_reg) begin
            case ({s_old_reg, s_reg})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd_step = 1'b1;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev_step = 1'b1;
                4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: dbl_step = 1'b1;
                default: ;
            endcase
        end
    end

    assign step_now = fwd_step | rev_step;

    // clr only touches position and error; step pulse and direction still follow the step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            err_reg  <= 1'b0;
            step_reg <= 1'b0;
        end else begin
            step_reg <= step_now;
            if (clr) begin
                cnt_reg <= '0;
                err_reg <= 1'b0;
            end else begin
                if (fwd_step)
                    cnt_reg <= cnt_reg + CNT_W'(1);
                else if (rev_step)
                    cnt_reg <= cnt_reg - CNT_W'(1);
                if (dbl_step)
                    err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_reg <= '0;
            dir_reg   <= 2'b00;
        end else if (step_now) begin
            stall_reg <= '0;
            dir_reg   <= fwd_step ? 2'b10 : 2'b01;
        end else if (stall_reg == STALL_LAST) begin
            dir_reg <= 2'b00;
        end else begin
            stall_reg <= stall_reg + STALL_W'(1);
        end
    end

    assign acc_sum = {1'b0, acc_reg} + {{SPD_W{1'b0}}, step_now};
    assign acc_sat = acc_sum[SPD_W] ? {SPD_W{1'b1}} : acc_sum[SPD_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_reg   <= '0;
            acc_reg   <= '0;
            speed_reg <= '0;
        end else if (win_reg == WIN_LAST) begin
            win_reg   <= '0;
            acc_reg   <= '0;
            speed_reg <= acc_sat;
        end else begin
            win_reg <= win_reg + WIN_W'(1);
            acc_reg <= acc_sat;
        end
    end

    assign cnt_out    = cnt_reg;
    assign dir_mode   = dir_reg;
    assign step_valid = step_reg;
    assign speed_out  = speed_reg;
    assign err        = err_reg;

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Reads the wheel's two-channel quadrature encoder (A/B) and recovers motion: direction, signed position count and step rate per time window.
- Receiver/decoder counterpart of the motor direction driver. `dir_mode` reports motion in the same 2-bit encoding the driver consumes: {pin1,pin2} = 10 forward, 01 reverse, 00 stopped.
- Sits between the encoder pins and the PWM/car control register interface.

Parameters:
- CNT_W, 16, width of position counter (two's complement, wraps).
- FILT_LEN, 3, consecutive identical synchronized samples needed to accept a new A/B level (min 2).
- STALL_CYC, 1000000, cycles with no valid step before `dir_mode` returns to 00.
- WIN_CYC, 100000, length of the speed measurement window in cycles.
- SPD_W, 12, width of speed output (saturating).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- enc_a  input  1  encoder channel A, asynchronous to clk.
- enc_b  input  1  encoder channel B, asynchronous to clk.
- clr  input  1  synchronous clear of position counter.
- cnt_out  output  CNT_W  signed position count.
- dir_mode  output  2  {fwd,rev}: 10 forward, 01 reverse, 00 stopped.
- step_valid  output  1  one-cycle pulse per accepted step.
- speed_out  output  SPD_W  valid steps counted in the last completed window.
- err  output  1  sticky: illegal double transition seen; cleared by rst or clr.

Behaviour:
- Reset (async, rst=1): all outputs 0.
  - Sync flops, filter history and filtered state load 00.
  - Stall, window and step accumulators load 0.
- Synchronizer: 2-FF chain per channel; no logic between the two stages.
- Filter:
  - Shift register of the last FILT_LEN synchronized {A,B} samples.
  - Filtered state S updates only when all FILT_LEN entries are equal and differ from S.
  - Pulses shorter than FILT_LEN cycles are ignored.
- Decode, on each S update, old->new with state written {A,B}:
  - Forward: 00->10->11->01->00. Reverse: exact opposite order.
  - Forward step: cnt_out+1. Reverse step: cnt_out-1. Wrap modulo 2^CNT_W, no saturation.
  - Valid step: step_valid=1 for exactly that cycle; dir_mode=10 or 01; stall counter reset to 0.
  - Double change (00<->11, 10<->01): no count, no step_valid, err<=1, dir_mode unchanged.
- Latency: an A/B level held stable reaches cnt_out, step_valid and dir_mode exactly FILT_LEN+3 clock edges after the first edge at which the pin shows the new level (6 at default).
- Stall:
  - Counter increments every cycle without a valid step.
  - When it reaches STALL_CYC-1, dir_mode<=00; the counter holds until the next step.
  - cnt_out is unaffected.
- Speed:
  - Free-running window counter runs 0..WIN_CYC-1.
  - Step accumulator counts valid steps in either direction, saturating at 2^SPD_W-1.
  - In the cycle the window counter equals WIN_CYC-1: speed_out<=accumulator plus any step in that cycle (saturated); accumulator<=0.
  - speed_out holds between windows.
- clr:
  - cnt_out<=0 and err<=0.
  - clr wins over a simultaneous step: cnt_out=0, but step_valid still pulses and dir_mode still updates.
  - Window, stall and speed logic are unaffected.
- Reset mid-motion: immediate return to reset values. After release, the first accepted level is treated as a transition from 00 and decoded under the normal rules, which may set err.

Test Plan:
- Reset, then drive forward sequence 10,11,01,00, each level held 20 cycles -> cnt_out=4, dir_mode=10, four step_valid pulses, each 6 cycles after its pin change.
- From cnt_out=0, drive one reverse step 10->00 (after a preceding 00->10 forward step) -> cnt_out returns 0 then wraps to 0xFFFF on the next reverse step 00->01; dir_mode=01.
- Glitch 2-cycle pulse on enc_a (FILT_LEN=3) -> no change to cnt_out, step_valid stays 0, err=0.
- Jump A/B 00->11 in one cycle -> cnt_out unchanged, err=1 sticky; then clr -> err=0, cnt_out=0.
- STALL_CYC=50: one forward step then idle -> dir_mode=10, then 00 exactly 50 cycles after the step_valid pulse.
- WIN_CYC=100, SPD_W=4, 20 forward steps per window -> speed_out=15 (saturated). With 7 steps per window -> speed_out=7 at the next window end.
